// File: rtl/enc_block_seq_if.sv
// Block sequencer bus: the cycle enable and mode select flowing in,
// the block position, strobes and encoder-valid flag flowing out.
// Ports: en, mode (master->slave); count, switch, tail, done,
// count_valid, and mode_err when ENC_BLOCK_SEQ_MODE_ERR_EN is defined
// (slave->master).
interface enc_block_seq_if #(
    parameter int CNT_W = 13
) ();
    logic             en;
    logic [1:0]       mode;
    logic [CNT_W-1:0] count;
    logic             switch;
    logic             tail;
    logic             done;
    logic             count_valid;
`ifdef ENC_BLOCK_SEQ_MODE_ERR_EN
    logic             mode_err;

    modport master (
        output en, mode,
        input  count, switch, tail, done, count_valid, mode_err
    );
    modport slave (
        input  en, mode,
        output count, switch, tail, done, count_valid, mode_err
    );
`else
    modport master (
        output en, mode,
        input  count, switch, tail, done, count_valid
    );
    modport slave (
        input  en, mode,
        output count, switch, tail, done, count_valid
    );
`endif
endinterface

// File: rtl/enc_block_seq.sv
// Encoder block sequencer: walks data indices of a mode-selected block
// length, then TAIL_LEN tail cycles, advancing only on en=1 cycles.
// Ports: clk, clr (async active-high reset), bus (enc_block_seq_if.slave:
// en, mode in; count, switch, tail, done, count_valid out).
// Optional: ENC_BLOCK_SEQ_MODE_ERR_EN adds sticky bus.mode_err.
module enc_block_seq #(
    parameter int CNT_W     = 13,
    parameter int BLK_LEN_0 = 6144,
    parameter int BLK_LEN_1 = 1056,
    parameter int BLK_LEN_2 = 64,
    parameter int BLK_LEN_3 = 8,
    parameter int TAIL_LEN  = 4,
    parameter int VALID_DLY = 5
) (
    input logic            clk,
    input logic            clr,
    enc_block_seq_if.slave bus
);
    localparam int TW = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [1:0]       mode_q;
    logic [TW-1:0]    tcnt;
    logic             tail;
    logic             count_valid;

    logic [1:0]       sel_mode;
    logic [CNT_W-1:0] last;
    logic [31:0]      pos;
    logic             last_tail;

    // The block length follows the live mode only in IDLE; once a block
    // is running the latched copy is used so mode edits cannot shorten it.
    always_comb begin
        sel_mode = (state == IDLE) ? bus.mode : mode_q;
        last     = CNT_W'(BLK_LEN_3 - 1);
        unique case (sel_mode)
            2'd0: last = CNT_W'(BLK_LEN_0 - 1);
            2'd1: last = CNT_W'(BLK_LEN_1 - 1);
            2'd2: last = CNT_W'(BLK_LEN_2 - 1);
            2'd3: last = CNT_W'(BLK_LEN_3 - 1);
        endcase
    end

    // 1-based enabled-cycle number within the block; IDLE holds count=0.
    always_comb begin
        if (state == TAIL)
            pos = 32'(last) + 32'd2 + 32'(tcnt);
        else
            pos = 32'(count) + 32'd1;
    end

    assign last_tail = (tcnt == TW'(TAIL_LEN - 1));

    assign bus.switch = !clr && bus.en && (state == DATA) && (count == last);
    assign bus.done   = !clr && bus.en && (state == TAIL) && last_tail;
    assign bus.count       = count;
    assign bus.tail        = tail;
    assign bus.count_valid = count_valid;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state       <= IDLE;
            count       <= '0;
            mode_q      <= 2'd0;
            tcnt        <= '0;
            tail        <= 1'b0;
            count_valid <= 1'b0;
        end else if (bus.en) begin
            if (pos == 32'(VALID_DLY))
                count_valid <= 1'b1;
            unique case (state)
                IDLE: begin
                    mode_q <= bus.mode;
                    count  <= CNT_W'(1);
                    state  <= DATA;
                end
                DATA: begin
                    if (count == last) begin
                        count <= '0;
                        tcnt  <= '0;
                        tail  <= 1'b1;
                        state <= TAIL;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                TAIL: begin
                    if (last_tail) begin
                        // Ending the block wins over a same-edge rise.
                        tcnt        <= '0;
                        tail        <= 1'b0;
                        count_valid <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ENC_BLOCK_SEQ_MODE_ERR_EN
    logic mode_err;

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            mode_err <= 1'b0;
        else if (bus.en && (state != IDLE) && (bus.mode != mode_q))
            mode_err <= 1'b1;
    end

    assign bus.mode_err = mode_err;
`endif

endmodule
